// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end that turns accepted bytes into UART write commands.
// Define UART_ARB_WATCHDOG_EN to build the stuck-transfer watchdog (timeout_err); otherwise it is tied off.
module uart_tx_arbiter #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000,
    parameter logic [2:0]  WR_INSTR       = 3'b001
) (
    input  logic        clock,
    input  logic        init_flag,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    input  logic        uart_ready_to_send,
    output logic        uart_enb,
    output logic [2:0]  uart_instruction,
    output logic [31:0] uart_write_value,
    output logic        busy,
    output logic        grant_id,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_id_q, grant_id_d;
    logic        req0_ready_q, req0_ready_d;
    logic        req1_ready_q, req1_ready_d;
    logic        uart_enb_q, uart_enb_d;
    logic [2:0]  uart_instruction_q, uart_instruction_d;
    logic [31:0] uart_write_value_q, uart_write_value_d;
    logic        busy_q, busy_d;
    logic        winner;
    logic        wd_expired;

`ifdef UART_ARB_WATCHDOG_EN
    logic [19:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic        in_wait;

    assign in_wait    = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    assign wd_expired = in_wait && (wd_cnt_q == TIMEOUT_CYCLES - 20'd1);

    // Counter restarts as the command is issued and runs for the whole UART handshake.
    always_comb begin
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = 1'b0;
        if (state_q == ISSUE) begin
            wd_cnt_d = '0;
        end else if (in_wait) begin
            if (wd_expired) begin
                wd_cnt_d      = '0;
                timeout_err_d = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 20'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge init_flag) begin
        if (init_flag) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d signal gets a default before the case so no path can infer a latch.
        state_d            = state_q;
        hold_d             = hold_q;
        last_grant_d       = last_grant_q;
        grant_id_d         = grant_id_q;
        req0_ready_d       = 1'b0;
        req1_ready_d       = 1'b0;
        uart_enb_d         = 1'b0;
        uart_instruction_d = 3'b000;
        uart_write_value_d = 32'h0;

        // On a tie the requester that did not win last time goes first.
        winner = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

        unique case (state_q)
            IDLE: begin
                if (uart_ready_to_send && (req0_valid || req1_valid)) begin
                    req0_ready_d = ~winner;
                    req1_ready_d = winner;
                    hold_d       = winner ? req1_data : req0_data;
                    last_grant_d = winner;
                    grant_id_d   = winner;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                uart_enb_d         = 1'b1;
                uart_instruction_d = WR_INSTR;
                uart_write_value_d = {24'h000000, hold_q};
                state_d            = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (wd_expired) begin
                    state_d = IDLE;
                end else if (!uart_ready_to_send) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (wd_expired || uart_ready_to_send) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge init_flag) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (init_flag) begin
            state_q            <= IDLE;
            hold_q             <= 8'h00;
            last_grant_q       <= 1'b1;
            grant_id_q         <= 1'b0;
            req0_ready_q       <= 1'b0;
            req1_ready_q       <= 1'b0;
            uart_enb_q         <= 1'b0;
            uart_instruction_q <= 3'b000;
            uart_write_value_q <= 32'h0;
            busy_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            hold_q             <= hold_d;
            last_grant_q       <= last_grant_d;
            grant_id_q         <= grant_id_d;
            req0_ready_q       <= req0_ready_d;
            req1_ready_q       <= req1_ready_d;
            uart_enb_q         <= uart_enb_d;
            uart_instruction_q <= uart_instruction_d;
            uart_write_value_q <= uart_write_value_d;
            busy_q             <= busy_d;
        end
    end

    assign req0_ready       = req0_ready_q;
    assign req1_ready       = req1_ready_q;
    assign uart_enb         = uart_enb_q;
    assign uart_instruction = uart_instruction_q;
    assign uart_write_value = uart_write_value_q;
    assign busy             = busy_q;
    assign grant_id         = grant_id_q;

endmodule
